fcvt_result_queue: RTL and testbench
====================================

Name: fcvt_result_queue

Overview:
- Downstream of the recoded-float-to-integer converter: captures each conversion result (integer, exception flags, typeOp, destination tag) into a small FIFO.
- Formats 32-bit results to full width and holds them until the integer writeback port accepts.
- On commit, accumulates exception flags into a sticky fflags register.
- Decouples the combinational converter from writeback-port stalls.

Parameters:
- INT_WIDTH, 64, result width; must equal converter output width.
- DEPTH, 4, FIFO entries; power of two, >= 2.
- TAG_WIDTH, 5, destination register tag width.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  converter result valid.
- in_ready  output  1  queue can accept.
- in_data  input  INT_WIDTH  converter integer result.
- in_flags  input  5  converter exceptionFlags, bit 4 = invalid.
- in_typeOp  input  2  conversion type (`type_uint32/`type_int32/`type_uint64/`type_int64).
- in_tag  input  TAG_WIDTH  destination tag.
- out_valid  output  1  head entry valid.
- out_ready  input  1  writeback accepts head.
- out_data  output  INT_WIDTH  formatted result.
- out_tag  output  TAG_WIDTH  head tag.
- fflags  output  5  sticky accumulated flags.
- fflags_clear  input  1  clear sticky flags.
- count  output  clog2(DEPTH)+1  current occupancy.

Behaviour:
- Reset (async, reset_n low):
  - rd/wr pointers = 0, count = 0, fflags = 0.
  - out_valid = 0, in_ready = 1.
  - out_data/out_tag = 0 (storage array not reset; outputs gated to 0 when empty).
- Enqueue: in_valid & in_ready at posedge writes the entry at wr_ptr; wr_ptr increments modulo DEPTH (natural wrap).
- Dequeue: out_valid & out_ready at posedge; rd_ptr increments modulo DEPTH.
- Formatting at enqueue, stored formatted:
  - `type_uint32 and `type_int32: data = sign-extend of in_data[31] over bits INT_WIDTH-1:32 (uint32 also sign-extended, per ISA convention).
  - 64-bit types: stored unchanged.
- Flags stored per entry, unmodified.
- Latency: entry enqueued at edge N is visible on out_valid after edge N; no combinational in-to-out bypass.
- in_ready = (count != DEPTH), registered-equivalent (depends only on state). When full, no enqueue even if a dequeue happens in the same cycle.
- out_valid = (count != 0); out_data/out_tag are the head entry.
- Simultaneous enqueue and dequeue (count not full, not empty): both occur, count unchanged.
- Enqueue into empty with out_ready high: no dequeue that cycle; head appears next cycle.
- count: +1 on enqueue only, -1 on dequeue only, unchanged when both or neither.
- fflags update: next = (fflags_clear ? 0 : fflags) | (dequeue ? head_flags : 0). A clear coinciding with a dequeue keeps the dequeued entry's flags.
- in_valid without in_ready: data ignored. Upstream must hold stable until accepted.
- out_valid, once high, stays high with stable head until out_ready.
- reset_n asserted mid-operation: all entries discarded immediately, outputs to reset values asynchronously.

Optional Feature:
- Macro: FCVT_QUEUE_FLUSH_EN.
- Defined:
  - Adds input port flush (1 bit). flush high at posedge sets pointers and count to 0, discards all entries.
  - Any enqueue or dequeue in that cycle is suppressed; fflags receives no contribution from the suppressed dequeue, but fflags_clear still applies.
  - out_valid = 0 the following cycle.
- Undefined: no flush port; queue emptied only by dequeue or reset.

Test Plan:
- Reset then idle -> out_valid=0, in_ready=1, count=0, fflags=0, out_data=0.
- Enqueue in_data=64'h00000000_80000000, typeOp=`type_int32, tag=3, flags=0 -> next cycle out_data=64'hFFFFFFFF_80000000, out_tag=3. Same data with `type_uint64 -> unchanged.
- Fill 4 entries with out_ready=0 -> count=4, in_ready=0; 5th in_valid ignored. Drain 4 -> tags in order, count=0, pointers wrapped to 0. Refill -> correct order.
- Steady stream, in_valid=out_ready=1 for 10 cycles at count=2 -> count stays 2, every entry emerges in order, no loss or duplicate.
- Dequeue entry with flags=5'h10, then 5'h01 -> fflags=5'h11. Assert fflags_clear on the same cycle as a dequeue with 5'h01 -> fflags=5'h01.
- Assert reset_n low mid-stream with count=3 -> out_valid and count drop to 0 without a clock edge. With FCVT_QUEUE_FLUSH_EN: flush at count=3 with simultaneous dequeue -> count=0, fflags unchanged.

Source files
------------

// File: rtl/fcvt_result_queue.sv
// fcvt_result_queue: FIFO of formatted float-to-int conversion results with sticky fflags (optional flush via FCVT_QUEUE_FLUSH_EN)
module fcvt_result_queue #(
  parameter int INT_WIDTH = 64,
  parameter int DEPTH     = 4,
  parameter int TAG_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     reset_n,
`ifdef FCVT_QUEUE_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [INT_WIDTH-1:0]     in_data,
  input  logic [4:0]               in_flags,
  input  logic [1:0]               in_typeOp,
  input  logic [TAG_WIDTH-1:0]     in_tag,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [INT_WIDTH-1:0]     out_data,
  output logic [TAG_WIDTH-1:0]     out_tag,
  output logic [4:0]               fflags,
  input  logic                     fflags_clear,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [1:0] TYPE_UINT32 = 2'b00;
  localparam logic [1:0] TYPE_INT32  = 2'b01;
  logic [INT_WIDTH-1:0] data_mem [DEPTH];
  logic [TAG_WIDTH-1:0] tag_mem [DEPTH];
  logic [4:0] flags_mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic flushing, enq, deq, is32;
  logic [INT_WIDTH-1:0] fmt_data;
`ifdef FCVT_QUEUE_FLUSH_EN
  assign flushing = flush;
`else
  assign flushing = 1'b0;
`endif
  assign in_ready  = count != FULL;
  assign out_valid = count != '0;
  assign enq = in_valid & in_ready & ~flushing;
  assign deq = out_valid & out_ready & ~flushing;
  assign is32 = (in_typeOp == TYPE_UINT32) || (in_typeOp == TYPE_INT32);
  assign fmt_data = is32 ? {{(INT_WIDTH-32){in_data[31]}}, in_data[31:0]} : in_data;
  assign out_data = out_valid ? data_mem[rd_ptr] : '0;
  assign out_tag  = out_valid ? tag_mem[rd_ptr] : '0;
  // Storage is not reset; empty-gating above hides stale contents.
  always_ff @(posedge clk) begin
    if (enq) begin
      data_mem[wr_ptr]  <= fmt_data;
      tag_mem[wr_ptr]   <= in_tag;
      flags_mem[wr_ptr] <= in_flags;
    end
  end
  // Pointers, occupancy and sticky flags; a dequeued entry's flags survive a same-cycle clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      fflags <= '0;
    end else begin
      rd_ptr <= flushing ? '0 : rd_ptr + AW'(deq);
      wr_ptr <= flushing ? '0 : wr_ptr + AW'(enq);
      count  <= flushing ? '0 : count + (AW+1)'(enq) - (AW+1)'(deq);
      fflags <= (fflags_clear ? 5'd0 : fflags) | (deq ? flags_mem[rd_ptr] : 5'd0);
    end
  end
endmodule

// File: tb/tb_fcvt_result_queue.sv
// tb_fcvt_result_queue: randomized and directed checks of fcvt_result_queue against a queue-based model
module tb_fcvt_result_queue;
  localparam logic [1:0] T_U32 = 2'd0, T_I32 = 2'd1, T_U64 = 2'd2, T_I64 = 2'd3;
  logic clk = 0, reset_n = 0;
  logic in_valid = 0, out_ready = 0, fflags_clear = 0;
  logic [63:0] in_data = '0;
  logic [4:0] in_flags = '0, in_tag = '0;
  logic [1:0] in_typeOp = '0;
  logic in_ready, out_valid;
  logic [63:0] out_data;
  logic [4:0] out_tag, fflags;
  logic [2:0] count;
`ifdef FCVT_QUEUE_FLUSH_EN
  logic flush = 0;
`endif
  int vectors = 0, miscompares = 0;
  logic [63:0] q_data[$];
  logic [4:0] q_tag[$], q_flags[$];
  logic [4:0] m_fflags = '0;
  logic m_enq;

  fcvt_result_queue dut (
    .clk(clk), .reset_n(reset_n),
`ifdef FCVT_QUEUE_FLUSH_EN
    .flush(flush),
`endif
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_flags(in_flags),
    .in_typeOp(in_typeOp), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_tag(out_tag), .fflags(fflags), .fflags_clear(fflags_clear),
    .count(count)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] fmt(input logic [63:0] d, input logic [1:0] t);
    return (t == T_U64 || t == T_I64) ? d : 64'($signed(d[31:0]));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    int n = q_data.size();
    chk("out_valid", 64'(out_valid), 64'(n != 0));
    chk("in_ready", 64'(in_ready), 64'(n != 4));
    chk("count", 64'(count), 64'(n));
    chk("fflags", 64'(fflags), 64'(m_fflags));
    chk("out_data", out_data, n != 0 ? q_data[0] : 64'd0);
    chk("out_tag", 64'(out_tag), n != 0 ? 64'(q_tag[0]) : 64'd0);
  endtask

  // Called just after a posedge; drives one cycle, checks at negedge, advances the model at the edge.
  task automatic step(input logic iv, input logic [63:0] d, input logic [4:0] f, input logic [1:0] t,
                      input logic [4:0] tg, input logic ordy, input logic clr, input logic fl);
    logic deq;
    logic [4:0] nf;
    in_valid = iv; in_data = d; in_flags = f; in_typeOp = t; in_tag = tg;
    out_ready = ordy; fflags_clear = clr;
`ifdef FCVT_QUEUE_FLUSH_EN
    flush = fl;
`else
    fl = 1'b0;
`endif
    @(negedge clk);
    check_model();
    m_enq = iv && q_data.size() < 4 && !fl;
    deq = q_data.size() > 0 && ordy && !fl;
    nf = (clr ? 5'd0 : m_fflags) | (deq ? q_flags[0] : 5'd0);
    @(posedge clk);
    m_fflags = nf;
    if (fl) begin
      q_data.delete(); q_tag.delete(); q_flags.delete();
    end
    if (deq) begin
      void'(q_data.pop_front()); void'(q_tag.pop_front()); void'(q_flags.pop_front());
    end
    if (m_enq) begin
      q_data.push_back(fmt(d, t)); q_tag.push_back(tg); q_flags.push_back(f);
    end
    #1;
  endtask

  task automatic idle(input logic ordy);
    step(0, 64'd0, 5'd0, T_I64, 5'd0, ordy, 0, 0);
  endtask

  initial begin
    logic iv;
    logic [63:0] d;
    logic [4:0] f, tg;
    logic [1:0] t;
    #12 reset_n = 1;
    @(posedge clk); #1;
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst in_ready", 64'(in_ready), 64'd1);
    chk("rst count", 64'(count), 64'd0);
    chk("rst fflags", 64'(fflags), 64'd0);
    chk("rst out_data", out_data, 64'd0);
    idle(0);
    // sign extension of 32-bit types, 64-bit passthrough
    step(1, 64'h00000000_80000000, 5'd0, T_I32, 5'd3, 0, 0, 0);
    chk("int32 data", out_data, 64'hFFFFFFFF_80000000);
    chk("int32 tag", 64'(out_tag), 64'd3);
    step(1, 64'h00000000_80000000, 5'd0, T_U64, 5'd4, 1, 0, 0);
    chk("uint64 data", out_data, 64'h00000000_80000000);
    chk("uint64 tag", 64'(out_tag), 64'd4);
    idle(1);
    chk("empty again", 64'(out_valid), 64'd0);
    // fill to full, 5th ignored, drain in order, refill
    for (int i = 0; i < 4; i++) step(1, 64'(i), 5'd0, T_U64, 5'(i), 0, 0, 0);
    chk("full count", 64'(count), 64'd4);
    chk("full in_ready", 64'(in_ready), 64'd0);
    step(1, 64'd99, 5'd0, T_U64, 5'd9, 0, 0, 0);
    chk("5th ignored", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("drain tag", 64'(out_tag), 64'(i));
      step(0, 64'd0, 5'd0, T_U64, 5'd0, 1, 0, 0);
    end
    chk("drained count", 64'(count), 64'd0);
    for (int i = 0; i < 3; i++) step(1, 64'(i + 20), 5'd0, T_U64, 5'(i + 20), 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 64'd0, 5'd0, T_U64, 5'd0, 1, 0, 0);
    // steady stream at count 2
    step(1, 64'd40, 5'd0, T_I64, 5'd10, 0, 0, 0);
    step(1, 64'd41, 5'd0, T_I64, 5'd11, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      chk("stream head", 64'(out_tag), 64'(10 + i));
      step(1, 64'(42 + i), 5'd0, T_I64, 5'(12 + i), 1, 0, 0);
      chk("stream count", 64'(count), 64'd2);
    end
    idle(1); idle(1);
    // sticky flags and clear-with-dequeue
    step(1, 64'd1, 5'h10, T_I64, 5'd1, 0, 1, 0);
    step(1, 64'd2, 5'h01, T_I64, 5'd2, 0, 0, 0);
    idle(1); idle(1);
    chk("fflags sticky", 64'(fflags), 64'h11);
    step(1, 64'd3, 5'h01, T_I64, 5'd3, 0, 0, 0);
    step(0, 64'd0, 5'd0, T_I64, 5'd0, 1, 1, 0);
    chk("clear with deq", 64'(fflags), 64'h01);
`ifdef FCVT_QUEUE_FLUSH_EN
    for (int i = 0; i < 3; i++) step(1, 64'(i), 5'h04, T_I64, 5'(i), 0, 0, 0);
    step(1, 64'd7, 5'h08, T_I64, 5'd7, 1, 0, 1);
    chk("flush count", 64'(count), 64'd0);
    chk("flush fflags", 64'(fflags), 64'h01);
    idle(0);
`endif
    // asynchronous reset mid-stream at count 3
    for (int i = 0; i < 3; i++) step(1, 64'(i), 5'h02, T_I64, 5'(i), 0, 0, 0);
    in_valid = 0; out_ready = 0; fflags_clear = 0;
    reset_n = 0;
    #1;
    chk("async rst out_valid", 64'(out_valid), 64'd0);
    chk("async rst count", 64'(count), 64'd0);
    chk("async rst fflags", 64'(fflags), 64'd0);
    chk("async rst out_data", out_data, 64'd0);
    q_data.delete(); q_tag.delete(); q_flags.delete(); m_fflags = '0;
    #1 reset_n = 1;
    @(posedge clk); #1;
    // randomized traffic; a refused input is held stable until accepted
    m_enq = 1;
    iv = 0; d = '0; f = '0; t = '0; tg = '0;
    for (int i = 0; i < 400; i++) begin
      if (!iv || m_enq) begin
        iv = ($urandom_range(0, 3) != 0);
        d = {$urandom, $urandom};
        f = 5'($urandom);
        t = 2'($urandom);
        tg = 5'($urandom);
      end
      step(iv, d, f, t, tg, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 40) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
